// File: rtl/uart_cmd_if.sv
// Handshake and register-bus signals between the uart byte ports, the command
// decoder and the register bus it drives.
interface uart_cmd_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data;

    // Decoder side: consumes rx bytes, produces tx bytes, masters the register bus.
    modport master (
        input  rx_byte, rx_valid, tx_ready, mem_rd_data,
        output rx_ready, tx_byte, tx_valid, mem_addr, mem_wr_en, mem_wr_data, mem_rd_en
    );

    // Environment side: uart ports and the register file.
    modport slave (
        output rx_byte, rx_valid, tx_ready, mem_rd_data,
        input  rx_ready, tx_byte, tx_valid, mem_addr, mem_wr_en, mem_wr_data, mem_rd_en
    );
endinterface

// File: rtl/uart_cmd.sv
// Serial command decoder: 'W' addr data -> register write, answers 'K';
// 'R' addr -> register read, answers the data; anything else answers '?'.
module uart_cmd #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 125000
) (
    input  logic       clock,
    input  logic       reset_n,
    uart_cmd_if.master bus,
    output logic [7:0] err_count
);
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ, READ_WAIT, SEND
    } state_t;

    localparam logic [7:0]  OP_WRITE     = 8'h57;
    localparam logic [7:0]  OP_READ      = 8'h52;
    localparam logic [7:0]  RSP_OK       = 8'h4B;
    localparam logic [7:0]  RSP_ERR      = 8'h3F;
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        is_write;
    logic [19:0] idle_cnt;
    logic        rx_fire;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Ready is a pure decode of the state so it is valid in the very first IDLE cycle.
    assign bus.rx_ready = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
    assign rx_fire      = bus.rx_valid && bus.rx_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            is_write        <= 1'b0;
            idle_cnt        <= '0;
            err_count       <= '0;
            bus.tx_byte     <= '0;
            bus.tx_valid    <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_data <= '0;
            bus.mem_rd_en   <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle; only the accepting edge raises them,
            // which makes each one exactly one cycle wide without extra clearing logic.
            bus.mem_wr_en <= 1'b0;
            bus.mem_rd_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        if (bus.rx_byte == OP_WRITE || bus.rx_byte == OP_READ) begin
                            is_write <= (bus.rx_byte == OP_WRITE);
                            idle_cnt <= '0;
                            state    <= GET_ADDR;
                        end else begin
                            bus.tx_byte  <= RSP_ERR;
                            bus.tx_valid <= 1'b1;
                            err_count    <= sat_inc(err_count);
                            state        <= SEND;
                        end
                    end
                end

                GET_ADDR: begin
                    if (rx_fire) begin
                        bus.mem_addr <= bus.rx_byte[ADDR_W-1:0];
                        idle_cnt     <= '0;
                        if (is_write) begin
                            state <= GET_DATA;
                        end else begin
                            bus.mem_rd_en <= 1'b1;
                            state         <= DO_READ;
                        end
                    end else if (idle_cnt == TIMEOUT_LAST) begin
                        idle_cnt  <= '0;
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 20'd1;
                    end
                end

                GET_DATA: begin
                    // An accepted byte wins over a timeout expiring on the same edge.
                    if (rx_fire) begin
                        bus.mem_wr_data <= bus.rx_byte;
                        bus.mem_wr_en   <= 1'b1;
                        idle_cnt        <= '0;
                        state           <= DO_WRITE;
                    end else if (idle_cnt == TIMEOUT_LAST) begin
                        idle_cnt  <= '0;
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 20'd1;
                    end
                end

                DO_WRITE: begin
                    bus.tx_byte  <= RSP_OK;
                    bus.tx_valid <= 1'b1;
                    state        <= SEND;
                end

                DO_READ: begin
                    state <= READ_WAIT;
                end

                READ_WAIT: begin
                    bus.tx_byte  <= bus.mem_rd_data;
                    bus.tx_valid <= 1'b1;
                    state        <= SEND;
                end

                SEND: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd.sv
// Directed bench for uart_cmd: write/read frames, unknown opcodes, inter-byte
// timeout, tx back-pressure, asynchronous reset and err_count saturation.
module tb_uart_cmd;
    localparam int T = 20;

    logic       clock;
    logic       reset_n;
    logic [7:0] err_count;

    uart_cmd_if #(.ADDR_W(8)) bus ();

    uart_cmd #(.ADDR_W(8), .TIMEOUT_CYCLES(T)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .err_count (err_count)
    );

    int compared   = 0;
    int mismatched = 0;
    int wr_cnt     = 0;
    int rd_cnt     = 0;
    int tx_cnt     = 0;
    int exp_err    = 0;

    logic [7:0] tb_mem [256];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Register file model: read data valid the cycle after mem_rd_en, garbage otherwise.
    always @(posedge clock) bus.mem_rd_data <= bus.mem_rd_en ? tb_mem[bus.mem_addr] : 8'hEE;

    always @(negedge clock) begin
        if (bus.mem_wr_en) wr_cnt++;
        if (bus.mem_rd_en) rd_cnt++;
        if (bus.tx_valid && bus.tx_ready) tx_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        @(negedge clock);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.rx_ready) begin
                @(posedge clock);
                ok = 1'b1;
            end else begin
                waits++;
                @(negedge clock);
            end
        end
        #1 bus.rx_valid = 1'b0;
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL send_byte: byte %02h not accepted, rx_ready got 0 required 1", b);
        end
    endtask

    task automatic get_resp(output logic [7:0] b);
        bit ok;
        ok = 1'b0;
        b  = 8'hxx;
        @(negedge clock);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.tx_valid) begin
                b = bus.tx_byte;
                @(posedge clock);
                ok = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        #1 bus.tx_ready = 1'b0;
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL get_resp: no response, tx_valid got 0 required 1");
        end
    endtask

    task automatic test_reset();
        #2;
        compared++; if (bus.tx_valid !== 1'b0) begin mismatched++; $display("FAIL rst_tx_valid got %b want 0", bus.tx_valid); end
        compared++; if (bus.tx_byte !== 8'h00) begin mismatched++; $display("FAIL rst_tx_byte got %02h want 00", bus.tx_byte); end
        compared++; if (bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0) begin mismatched++; $display("FAIL rst_strobes got wr=%b rd=%b want 0 0", bus.mem_wr_en, bus.mem_rd_en); end
        compared++; if (bus.mem_addr !== 8'h00 || bus.mem_wr_data !== 8'h00) begin mismatched++; $display("FAIL rst_bus got addr=%02h data=%02h want 00 00", bus.mem_addr, bus.mem_wr_data); end
        compared++; if (err_count !== 8'h00) begin mismatched++; $display("FAIL rst_err got %02h want 00", err_count); end
        compared++; if (bus.rx_ready !== 1'b1) begin mismatched++; $display("FAIL rst_rx_ready got %b want 1", bus.rx_ready); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_write();
        int w; int wr0; int rd0; logic [7:0] r;
        wr0 = wr_cnt; rd0 = rd_cnt;
        send_byte(8'h57, w);
        send_byte(8'h10, w);
        send_byte(8'hA5, w);
        compared++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 8'h10 || bus.mem_wr_data !== 8'hA5)
            begin mismatched++; $display("FAIL wr_strobe got en=%b addr=%02h data=%02h want 1 10 a5", bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data); end
        compared++; if (bus.tx_valid !== 1'b0) begin mismatched++; $display("FAIL wr_tx_early got %b want 0", bus.tx_valid); end
        @(posedge clock); #1;
        compared++; if (bus.mem_wr_en !== 1'b0 || bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h4B)
            begin mismatched++; $display("FAIL wr_resp got en=%b valid=%b byte=%02h want 0 1 4b", bus.mem_wr_en, bus.tx_valid, bus.tx_byte); end
        get_resp(r);
        compared++; if (r !== 8'h4B) begin mismatched++; $display("FAIL wr_resp_byte got %02h want 4b", r); end
        compared++; if (wr_cnt - wr0 != 1 || rd_cnt != rd0) begin mismatched++; $display("FAIL wr_pulses got wr=%0d rd=%0d want 1 0", wr_cnt - wr0, rd_cnt - rd0); end
        compared++; if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin mismatched++; $display("FAIL wr_idle got ready=%b valid=%b want 1 0", bus.rx_ready, bus.tx_valid); end
    endtask

    task automatic test_read(input logic [7:0] addr, input logic [7:0] exp);
        int w; int wr0; int rd0; logic [7:0] r;
        wr0 = wr_cnt; rd0 = rd_cnt;
        send_byte(8'h52, w);
        send_byte(addr, w);
        compared++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== addr)
            begin mismatched++; $display("FAIL rd_strobe got en=%b addr=%02h want 1 %02h", bus.mem_rd_en, bus.mem_addr, addr); end
        @(posedge clock); #1;
        compared++; if (bus.mem_rd_en !== 1'b0 || bus.tx_valid !== 1'b0)
            begin mismatched++; $display("FAIL rd_wait got en=%b valid=%b want 0 0", bus.mem_rd_en, bus.tx_valid); end
        @(posedge clock); #1;
        compared++; if (bus.tx_valid !== 1'b1 || bus.tx_byte !== exp)
            begin mismatched++; $display("FAIL rd_resp got valid=%b byte=%02h want 1 %02h", bus.tx_valid, bus.tx_byte, exp); end
        get_resp(r);
        compared++; if (r !== exp) begin mismatched++; $display("FAIL rd_resp_byte got %02h want %02h", r, exp); end
        compared++; if (rd_cnt - rd0 != 1 || wr_cnt != wr0) begin mismatched++; $display("FAIL rd_pulses got rd=%0d wr=%0d want 1 0", rd_cnt - rd0, wr_cnt - wr0); end
    endtask

    task automatic test_unknown(input logic [7:0] b);
        int w; logic [7:0] r;
        send_byte(b, w);
        exp_err++;
        compared++; if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h3F || err_count !== 8'(exp_err))
            begin mismatched++; $display("FAIL unk_%02h got valid=%b byte=%02h err=%0d want 1 3f %0d", b, bus.tx_valid, bus.tx_byte, err_count, exp_err); end
        get_resp(r);
        compared++; if (r !== 8'h3F) begin mismatched++; $display("FAIL unk_resp got %02h want 3f", r); end
    endtask

    task automatic test_timeout();
        int w; int wr0; int tx0; logic [7:0] r;
        wr0 = wr_cnt; tx0 = tx_cnt;
        // Silence in GET_DATA.
        send_byte(8'h57, w);
        send_byte(8'h10, w);
        repeat (T - 1) @(posedge clock);
        #1;
        compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL to_data_early got err=%0d want %0d", err_count, exp_err); end
        @(posedge clock); #1;
        exp_err++;
        compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL to_data got err=%0d want %0d", err_count, exp_err); end
        // Silence in GET_ADDR.
        send_byte(8'h52, w);
        repeat (T - 1) @(posedge clock);
        #1;
        compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL to_addr_early got err=%0d want %0d", err_count, exp_err); end
        @(posedge clock); #1;
        exp_err++;
        compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL to_addr got err=%0d want %0d", err_count, exp_err); end
        compared++; if (wr_cnt != wr0 || tx_cnt != tx0 || rd_cnt < 0 || bus.tx_valid !== 1'b0)
            begin mismatched++; $display("FAIL to_quiet got wr=%0d tx=%0d valid=%b want 0 0 0", wr_cnt - wr0, tx_cnt - tx0, bus.tx_valid); end
        // Data byte lands exactly on the expiring edge, after a slow address byte.
        send_byte(8'h57, w);
        repeat (10) @(posedge clock);
        send_byte(8'h44, w);
        repeat (T - 1) @(posedge clock);
        send_byte(8'h99, w);
        compared++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 8'h44 || bus.mem_wr_data !== 8'h99 || err_count !== 8'(exp_err))
            begin mismatched++; $display("FAIL to_edge got en=%b addr=%02h data=%02h err=%0d want 1 44 99 %0d", bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, err_count, exp_err); end
        get_resp(r);
        compared++; if (r !== 8'h4B) begin mismatched++; $display("FAIL to_edge_resp got %02h want 4b", r); end
    endtask

    task automatic test_back_pressure();
        int w; int bad; int tx0; logic [7:0] r;
        bad = 0;
        send_byte(8'h00, w);
        exp_err++;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h3F || bus.rx_ready !== 1'b0) bad++;
        end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        tx0 = tx_cnt;
        get_resp(r);
        compared++; if (r !== 8'h3F || tx_cnt - tx0 != 1) begin mismatched++; $display("FAIL hold_release got byte=%02h handshakes=%0d want 3f 1", r, tx_cnt - tx0); end
        compared++; if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin mismatched++; $display("FAIL hold_idle got ready=%b valid=%b want 1 0", bus.rx_ready, bus.tx_valid); end
    endtask

    task automatic test_back_to_back();
        int w; logic [7:0] r;
        send_byte(8'h52, w);
        compared++; if (w != 0) begin mismatched++; $display("FAIL b2b_first got %0d wait cycles want 0", w); end
        send_byte(8'h01, w);
        get_resp(r);
        compared++; if (r !== 8'h4B) begin mismatched++; $display("FAIL b2b_resp got %02h want 4b", r); end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        send_byte(8'h57, w);
        send_byte(8'h33, w);
        #2 reset_n = 1'b0;
        #1;
        exp_err = 0;
        compared++; if (bus.mem_addr !== 8'h00 || bus.mem_wr_data !== 8'h00 || bus.tx_byte !== 8'h00)
            begin mismatched++; $display("FAIL arst_bus got addr=%02h data=%02h tx=%02h want 00 00 00", bus.mem_addr, bus.mem_wr_data, bus.tx_byte); end
        compared++; if (err_count !== 8'h00 || bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0)
            begin mismatched++; $display("FAIL arst_ctrl got err=%0d ready=%b valid=%b want 0 1 0", err_count, bus.rx_ready, bus.tx_valid); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_saturation();
        int w; int bad; logic [7:0] r;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            send_byte((i % 2 == 0) ? 8'h41 : 8'h72, w);
            get_resp(r);
            if (r !== 8'h3F) bad++;
            if (i == 253) begin
                compared++; if (err_count !== 8'd254) begin mismatched++; $display("FAIL sat_254 got %0d want 254", err_count); end
            end
            if (i == 254) begin
                compared++; if (err_count !== 8'd255) begin mismatched++; $display("FAIL sat_255 got %0d want 255", err_count); end
            end
        end
        compared++; if (err_count !== 8'd255) begin mismatched++; $display("FAIL sat_hold got %0d want 255", err_count); end
        compared++; if (bad != 0) begin mismatched++; $display("FAIL sat_resp got %0d wrong responses want 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'h4A;
        reset_n      = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;

        test_reset();
        test_write();
        test_read(8'h10, 8'h5A);
        test_read(8'h57, 8'h1D);
        test_unknown(8'h41);
        test_unknown(8'h77);
        test_read(8'h22, 8'h68);
        test_timeout();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
